// File: rtl/pa_dcache_refill_wr.sv
// D-cache line refill writer: accepts a refill request, writes four 64-bit beats into the
// data array of the target way, then installs the tag and updates the dirty/LRU entry.
module pa_dcache_refill_wr (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        req_vld,
   output logic        req_rdy,
   input  logic [9:0]  req_idx,
   input  logic        req_way,
   input  logic [21:0] req_tag,
   input  logic        beat_vld,
   input  logic [63:0] beat_data,
   input  logic        beat_err,
   output logic        beat_rdy,
   input  logic        arb_grant,
   output logic        refill_busy,
   output logic        refill_done,
   output logic        refill_err,
   output logic        dcache_data_cen_way0_bank0,
   output logic        dcache_data_cen_way0_bank1,
   output logic        dcache_data_cen_way1_bank0,
   output logic        dcache_data_cen_way1_bank1,
   output logic [3:0]  dcache_data_wen,
   output logic [11:0] dcache_data_idx,
   output logic [63:0] dcache_data_din,
   output logic        dcache_tag_cen,
   output logic [1:0]  dcache_tag_wen,
   output logic [9:0]  dcache_tag_idx,
   output logic [22:0] dcache_tag_din,
   output logic        dcache_dirty_cen,
   output logic [2:0]  dcache_dirty_wen,
   output logic [9:0]  dcache_dirty_idx,
   output logic [2:0]  dcache_dirty_din
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      TAG  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  cnt;
   logic        err_flag;
   logic [9:0]  idx_q;
   logic        way_q;
   logic [21:0] tag_q;
   logic        done_q;
   logic        done_err_q;

   logic accept;
   logic xfer;
   logic tag_wr;

   assign accept = (state == IDLE) & req_vld;
   assign xfer   = (state == FILL) & beat_vld & arb_grant;
   assign tag_wr = (state == TAG) & arb_grant;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         err_flag   <= 1'b0;
         idx_q      <= 10'd0;
         way_q      <= 1'b0;
         tag_q      <= 22'd0;
         done_q     <= 1'b0;
         done_err_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         done_q     <= tag_wr;
         done_err_q <= tag_wr & err_flag;
         if (accept) begin
            idx_q    <= req_idx;
            way_q    <= req_way;
            tag_q    <= req_tag;
            cnt      <= 2'd0;
            err_flag <= 1'b0;
         end else if (xfer) begin
            cnt      <= cnt + 2'd1;
            err_flag <= err_flag | beat_err;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = FILL;
         FILL:    if (xfer && cnt == 2'd3) state_nxt = TAG;
         TAG:     if (tag_wr) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Array drives are combinational so a granted beat lands in the same cycle.
   always_comb begin
      dcache_data_cen_way0_bank0 = 1'b1;
      dcache_data_cen_way0_bank1 = 1'b1;
      dcache_data_cen_way1_bank0 = 1'b1;
      dcache_data_cen_way1_bank1 = 1'b1;
      dcache_data_wen            = 4'b1111;
      dcache_data_idx            = 12'd0;
      dcache_data_din            = 64'd0;
      dcache_tag_cen             = 1'b1;
      dcache_tag_wen             = 2'b11;
      dcache_tag_idx             = 10'd0;
      dcache_tag_din             = 23'd0;
      dcache_dirty_cen           = 1'b1;
      dcache_dirty_wen           = 3'b111;
      dcache_dirty_idx           = 10'd0;
      dcache_dirty_din           = 3'b000;
      if (xfer) begin
         dcache_data_cen_way0_bank0 = way_q;
         dcache_data_cen_way0_bank1 = way_q;
         dcache_data_cen_way1_bank0 = ~way_q;
         dcache_data_cen_way1_bank1 = ~way_q;
         dcache_data_wen            = 4'b0000;
         dcache_data_idx            = {idx_q, cnt};
         dcache_data_din            = beat_data;
      end
      if (tag_wr) begin
         dcache_tag_cen          = 1'b0;
         dcache_tag_wen[way_q]   = 1'b0;
         dcache_tag_idx          = idx_q;
         dcache_tag_din          = {~err_flag, tag_q};
         dcache_dirty_cen        = 1'b0;
         dcache_dirty_idx        = idx_q;
         dcache_dirty_wen[way_q] = 1'b0;
         dcache_dirty_wen[2]     = 1'b0;
         // Freshly filled line is clean; LRU points at the way not just filled.
         dcache_dirty_din[2]     = ~way_q;
      end
   end

   assign req_rdy     = (state == IDLE);
   assign beat_rdy    = (state == FILL) & arb_grant;
   assign refill_busy = (state != IDLE);
   assign refill_done = done_q;
   assign refill_err  = done_err_q;

endmodule

// File: tb/tb_pa_dcache_refill_wr.sv
// Bench for pa_dcache_refill_wr: a beat-counting transaction model checked every cycle,
// plus literal expectations for the directed refill scenarios.
module tb_pa_dcache_refill_wr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_vld;
   logic        req_rdy;
   logic [9:0]  req_idx;
   logic        req_way;
   logic [21:0] req_tag;
   logic        beat_vld;
   logic [63:0] beat_data;
   logic        beat_err;
   logic        beat_rdy;
   logic        arb_grant;
   logic        refill_busy;
   logic        refill_done;
   logic        refill_err;
   logic        cen00, cen01, cen10, cen11;
   logic [3:0]  data_wen;
   logic [11:0] data_idx;
   logic [63:0] data_din;
   logic        tag_cen;
   logic [1:0]  tag_wen;
   logic [9:0]  tag_idx;
   logic [22:0] tag_din;
   logic        dirty_cen;
   logic [2:0]  dirty_wen;
   logic [9:0]  dirty_idx;
   logic [2:0]  dirty_din;

   int total = 0;
   int bad   = 0;

   pa_dcache_refill_wr dut (
      .forever_cpuclk             (clk),
      .cpurst_b                   (rst_n),
      .req_vld                    (req_vld),
      .req_rdy                    (req_rdy),
      .req_idx                    (req_idx),
      .req_way                    (req_way),
      .req_tag                    (req_tag),
      .beat_vld                   (beat_vld),
      .beat_data                  (beat_data),
      .beat_err                   (beat_err),
      .beat_rdy                   (beat_rdy),
      .arb_grant                  (arb_grant),
      .refill_busy                (refill_busy),
      .refill_done                (refill_done),
      .refill_err                 (refill_err),
      .dcache_data_cen_way0_bank0 (cen00),
      .dcache_data_cen_way0_bank1 (cen01),
      .dcache_data_cen_way1_bank0 (cen10),
      .dcache_data_cen_way1_bank1 (cen11),
      .dcache_data_wen            (data_wen),
      .dcache_data_idx            (data_idx),
      .dcache_data_din            (data_din),
      .dcache_tag_cen             (tag_cen),
      .dcache_tag_wen             (tag_wen),
      .dcache_tag_idx             (tag_idx),
      .dcache_tag_din             (tag_din),
      .dcache_dirty_cen           (dirty_cen),
      .dcache_dirty_wen           (dirty_wen),
      .dcache_dirty_idx           (dirty_idx),
      .dcache_dirty_din           (dirty_din)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a refill is active until 4 beats land and a granted tag cycle passes.
   logic        m_active = 1'b0;
   logic [9:0]  m_idx    = '0;
   logic        m_way    = 1'b0;
   logic [21:0] m_tag    = '0;
   int          m_beats  = 0;
   logic        m_err    = 1'b0;
   logic        m_done_pend = 1'b0;
   logic        m_done_err  = 1'b0;

   // Observations of DUT array activity, written only by the compare process.
   logic [11:0] obs_idx[$];
   int          n_tag = 0;
   int          n_done = 0;
   logic [22:0] last_tag_din = '0;
   logic [1:0]  last_tag_wen = '0;
   logic [2:0]  last_dirty_din = '0;
   logic [2:0]  last_dirty_wen = '0;
   logic        last_done_err = 1'b0;

   always @(negedge clk) begin
      logic xfer, tagw, accept;
      if (!rst_n) begin
         m_active = 1'b0; m_idx = '0; m_way = 1'b0; m_tag = '0;
         m_beats = 0; m_err = 1'b0; m_done_pend = 1'b0; m_done_err = 1'b0;
      end
      accept = !m_active && req_vld;
      xfer   = m_active && m_beats < 4 && beat_vld && arb_grant;
      tagw   = m_active && m_beats == 4 && arb_grant;

      check("req_rdy", req_rdy, !m_active);
      check("busy", refill_busy, m_active);
      check("beat_rdy", beat_rdy, m_active && m_beats < 4 && arb_grant);
      check("data_cen", {cen11, cen10, cen01, cen00},
            xfer ? (m_way ? 4'b0011 : 4'b1100) : 4'b1111);
      check("data_wen", data_wen, xfer ? 4'b0000 : 4'b1111);
      check("data_idx", data_idx, xfer ? {m_idx, 2'(m_beats)} : 12'd0);
      check("data_din", data_din, xfer ? beat_data : 64'd0);
      check("tag_cen", tag_cen, !tagw);
      check("tag_wen", tag_wen, tagw ? (m_way ? 2'b01 : 2'b10) : 2'b11);
      check("tag_idx", tag_idx, tagw ? m_idx : 10'd0);
      check("tag_din", tag_din, tagw ? {!m_err, m_tag} : 23'd0);
      check("dirty_cen", dirty_cen, !tagw);
      check("dirty_wen", dirty_wen, tagw ? (m_way ? 3'b001 : 3'b010) : 3'b111);
      check("dirty_idx", dirty_idx, tagw ? m_idx : 10'd0);
      check("dirty_din", dirty_din, tagw ? {!m_way, 2'b00} : 3'b000);
      check("done", refill_done, m_done_pend);
      check("err", refill_err, m_done_pend & m_done_err);

      if (data_wen == 4'h0) obs_idx.push_back(data_idx);
      if (!tag_cen) begin
         n_tag++;
         last_tag_din = tag_din; last_tag_wen = tag_wen;
         last_dirty_din = dirty_din; last_dirty_wen = dirty_wen;
      end
      if (refill_done) begin
         n_done++;
         last_done_err = refill_err;
      end

      if (rst_n) begin
         m_done_pend = tagw;
         m_done_err  = m_err;
         if (accept) begin
            m_active = 1'b1; m_idx = req_idx; m_way = req_way; m_tag = req_tag;
            m_beats = 0; m_err = 1'b0;
         end else if (xfer) begin
            m_beats++;
            m_err = m_err | beat_err;
         end else if (tagw) begin
            m_active = 1'b0;
         end
      end
   end

   task automatic send_req(input logic [9:0] idx, input logic way, input logic [21:0] tag);
      int n;
      req_vld = 1'b1; req_idx = idx; req_way = way; req_tag = tag;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_rdy && n < 20);
      check("req_accept_timeout", n < 20, 1'b1);
      @(posedge clk); #1;
      req_vld = 1'b0;
   endtask

   // Streams 4 beats; leaves the bench one cycle into the tag phase with grant low.
   task automatic do_beats(input int err_beat, input bit toggle);
      int sent, cyc;
      sent = 0; cyc = 0;
      while (sent < 4 && cyc < 40) begin
         beat_vld  = 1'b1;
         arb_grant = toggle ? cyc[0] : 1'b1;
         beat_data = {32'hA5A50000 + 32'(sent), 32'(cyc * 7 + 3)};
         beat_err  = (sent == err_beat);
         @(negedge clk);
         if (arb_grant) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      check("beats_timeout", sent, 4);
      beat_vld = 1'b0; arb_grant = 1'b0; beat_err = 1'b0;
   endtask

   task automatic do_tag(input int wait_cycles);
      arb_grant = 1'b0;
      repeat (wait_cycles) begin @(posedge clk); #1; end
      arb_grant = 1'b1;
      @(posedge clk); #1;
      arb_grant = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int b_idx, b_tag, b_done;
      rst_n = 1'b0;
      req_vld = 0; req_idx = '0; req_way = 0; req_tag = '0;
      beat_vld = 0; beat_data = '0; beat_err = 0; arb_grant = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_rdy", req_rdy, 1'b1);
      check("rst_beat_rdy", beat_rdy, 1'b0);
      @(posedge clk); #1;

      // Clean refill into way 1.
      b_idx = obs_idx.size(); b_tag = n_tag; b_done = n_done;
      send_req(10'h155, 1'b1, 22'h2ABCDE);
      do_beats(-1, 1'b0);
      do_tag(0);
      check("t1_nbeats", obs_idx.size() - b_idx, 4);
      for (int i = 0; i < 4; i++) check("t1_idx", obs_idx[b_idx + i], 12'h554 + 12'(i));
      check("t1_tag_wen", last_tag_wen, 2'b01);
      check("t1_tag_din", last_tag_din, 23'h6ABCDE);
      check("t1_dirty_wen", last_dirty_wen, 3'b001);
      check("t1_dirty_din", last_dirty_din, 3'b000);
      check("t1_ntag", n_tag - b_tag, 1);
      check("t1_ndone", n_done - b_done, 1);
      check("t1_err", last_done_err, 1'b0);

      // Errored beat 2 into way 0: still written, tag installed invalid.
      b_idx = obs_idx.size(); b_done = n_done;
      send_req(10'h0AA, 1'b0, 22'h123456);
      do_beats(2, 1'b0);
      do_tag(0);
      check("t2_nbeats", obs_idx.size() - b_idx, 4);
      check("t2_idx2", obs_idx[b_idx + 2], 12'h2AA);
      check("t2_tag_din", last_tag_din, 23'h123456);
      check("t2_tag_wen", last_tag_wen, 2'b10);
      check("t2_dirty_wen", last_dirty_wen, 3'b010);
      check("t2_dirty_din", last_dirty_din, 3'b100);
      check("t2_ndone", n_done - b_done, 1);
      check("t2_err", last_done_err, 1'b1);

      // Grant toggling with beat_vld held.
      b_idx = obs_idx.size();
      send_req(10'h3C3, 1'b1, 22'h00F00F);
      do_beats(-1, 1'b1);
      do_tag(0);
      check("t3_nbeats", obs_idx.size() - b_idx, 4);
      check("t3_idx3", obs_idx[b_idx + 3], 12'hF0F);

      // Grant without beat, then a tag phase that waits 3 cycles for grant.
      b_idx = obs_idx.size(); b_tag = n_tag;
      send_req(10'h001, 1'b0, 22'h3FFFFF);
      arb_grant = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("t4_nowrite_idle_grant", obs_idx.size() - b_idx, 0);
      do_beats(-1, 1'b0);
      do_tag(3);
      check("t4_ntag", n_tag - b_tag, 1);
      check("t4_tag_din", last_tag_din, 23'h7FFFFF);

      // Reset after the first beat aborts the refill.
      b_idx = obs_idx.size(); b_tag = n_tag; b_done = n_done;
      send_req(10'h3FF, 1'b0, 22'h111111);
      beat_vld = 1'b1; arb_grant = 1'b1; beat_data = 64'hDEAD_BEEF_0000_0001;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("t5_data_cen", {cen11, cen10, cen01, cen00}, 4'b1111);
      check("t5_data_wen", data_wen, 4'b1111);
      check("t5_tag_dirty_cen", {tag_cen, dirty_cen}, 2'b11);
      beat_vld = 1'b0; arb_grant = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      arb_grant = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      arb_grant = 1'b0;
      check("t5_nbeats", obs_idx.size() - b_idx, 1);
      check("t5_ntag", n_tag - b_tag, 0);
      check("t5_ndone", n_done - b_done, 0);
      check("t5_req_rdy", req_rdy, 1'b1);

      // Back-to-back: second request accepted in the done cycle.
      send_req(10'h022, 1'b1, 22'h0ABCDE);
      do_beats(-1, 1'b0);
      req_vld = 1'b1; req_idx = 10'h2C1; req_way = 1'b0; req_tag = 22'h155555;
      arb_grant = 1'b1;
      @(posedge clk); #1;
      arb_grant = 1'b0;
      @(negedge clk);
      check("t6_done_cycle_done", refill_done, 1'b1);
      check("t6_done_cycle_rdy", req_rdy, 1'b1);
      @(posedge clk); #1;
      req_vld = 1'b0;
      b_idx = obs_idx.size();
      do_beats(-1, 1'b0);
      do_tag(0);
      check("t6_first_idx", obs_idx[b_idx], 12'hB04);
      check("t6_tag_din", last_tag_din, 23'h555555);
      check("t6_dirty_din", last_dirty_din, 3'b100);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pa_dcache_refill_wr.md
PA_DCACHE_REFILL_WR -- requirements
Module: pa_dcache_refill_wr

Interface
REQ-001 SHALL have no parameters; line = 4 beats x 64 bits, 1024 sets, 2 ways, all fixed.
REQ-002 SHALL have one clock and an asynchronous active-low reset: forever_cpuclk, cpurst_b.
REQ-003 forever_cpuclk  in  1  sole clock, all flops rising-edge.
REQ-004 cpurst_b  in  1  asynchronous active-low reset.
REQ-005 req_vld  in  1  refill request valid.
REQ-006 req_rdy  out  1  request accepted when req_vld&req_rdy.
REQ-007 req_idx  in  10  set index; req_way in 1 target way; req_tag in 22 tag to install.
REQ-008 beat_vld  in  1; beat_data in 64; beat_err in 1 (bus error on this beat); beat_rdy out 1.
REQ-009 arb_grant  in  1  array port granted this cycle; no array access without it.
REQ-010 refill_busy  out  1; refill_done out 1 (pulse); refill_err out 1 (valid with refill_done).
REQ-011 dcache_data_cen_way{0,1}_bank{0,1} out 1 each, active-low; dcache_data_wen out 4, active-low; dcache_data_idx out 12; dcache_data_din out 64.
REQ-012 dcache_tag_cen out 1; dcache_tag_wen out 2 (bit n = way n, active-low); dcache_tag_idx out 10; dcache_tag_din out 23 = {valid, tag[21:0]}.
REQ-013 dcache_dirty_cen out 1; dcache_dirty_wen out 3; dcache_dirty_idx out 10; dcache_dirty_din out 3 = {lru, dirty_way1, dirty_way0}.

Function
REQ-014 SHALL implement states IDLE, FILL, TAG; req_rdy = (state==IDLE).
REQ-015 On accept SHALL latch idx, way, tag, clear beat counter (2 bits) and error flag, enter FILL next cycle.
REQ-016 In FILL: beat_rdy = arb_grant; beat transfers on beat_vld&beat_rdy.
REQ-017 On each transfer SHALL drive, same cycle (combinational): both bank cen of latched way low, other way cen high, data_wen=4'b0000, data_idx={idx,cnt}, data_din=beat_data.
REQ-018 Counter SHALL increment per transfer; error flag SHALL OR in beat_err; transfer with cnt==3 SHALL move to TAG.
REQ-019 beat_vld without grant, or grant without beat_vld, SHALL hold state and counter, no array access.
REQ-020 In TAG with arb_grant, one cycle: tag_cen=0, tag_wen[way]=0, other bit 1, tag_idx=idx, tag_din={~err_flag, tag}.
REQ-021 Same cycle: dirty_cen=0, dirty_idx=idx, dirty_wen[way]=0, dirty_wen[2]=0, other bit 1; dirty_din[way]=0, dirty_din[2]=~way, other bit 0.
REQ-022 TAG without grant SHALL hold with no access; after the tag write SHALL return to IDLE.
REQ-023 refill_done SHALL pulse one cycle, registered, in the cycle after the tag write; refill_err = error flag in that cycle, else 0.
REQ-024 refill_busy = (state!=IDLE); new request accepted earliest the cycle after the tag write (done-cycle overlap allowed).
REQ-025 Idle array outputs: all cen=1, all wen bits=1, idx/din=0.
REQ-026 An errored beat SHALL still be written; only the tag valid bit reflects the error.

Reset
REQ-027 cpurst_b low SHALL force IDLE, counter 0, error flag 0, latched fields 0, refill_done 0, immediately and asynchronously.
REQ-028 Reset mid-FILL or mid-TAG SHALL abort without further array writes; all cen/wen return to 1 during reset.
REQ-029 After release SHALL have req_rdy=1, beat_rdy=0.

Verification
REQ-030 Req idx=0x155, way=1, tag=0x2ABCDE, 4 beats, grant=1 -> data writes idx 0x554..0x557 on way1 banks only; tag wen=2'b01, din=0x6ABCDE; dirty wen=3'b001, din=3'b000; done 1 cycle later, err=0.
REQ-031 Same, way=0, beat 2 beat_err=1 -> all 4 beats written; tag din valid=0; dirty din=3'b100; refill_err=1 with done.
REQ-032 arb_grant toggled 0/1 every cycle with beat_vld held 1 -> exactly 4 writes, each only on grant cycles, beat_rdy mirrors grant.
REQ-033 TAG entered with grant=0 for 3 cycles -> no tag/dirty access until grant, then exactly one write.
REQ-034 cpurst_b asserted after beat 1 -> all cen=1 immediately; after release IDLE, no tag write, no done pulse.
REQ-035 Back-to-back requests (req_vld held) -> second accepted in done cycle, counter restarts at 0, idx of second used.
